// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines.
// Serves MEM-stage loads/stores and resolves misses via a single-outstanding memory handshake.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for a request; latches address/data/wen when one arrives
// COMPARE   | tag lookup; completes on hit, otherwise picks writeback or fill
// WRITEBACK | dirty victim line being written to memory
// ALLOCATE  | line fill from memory; returns to COMPARE, which then always hits
module dcache_ctrl #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cache_req_valid,
  input  logic        cache_req_wen,
  input  logic [31:0] cache_req_addr,
  input  logic [31:0] cache_req_data,
  output logic        cache_resp_valid,
  output logic [31:0] cache_resp_data,
  output logic        cache_stall,
  output logic        mem_req_valid,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t state, state_nx;

  logic [29:0]           req_word;
  logic [31:0]           req_data;
  logic                  req_wen;
  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      dirty_q;
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  line_hit;
  logic                  accept;
  logic                  fill_done;
  logic                  store_hit;
  logic                  unused_addr_bits;

  // Byte offset within the word has no meaning for a word-granular cache.
  assign unused_addr_bits = ^cache_req_addr[1:0];

  assign idx       = req_word[INDEX_BITS-1:0];
  assign req_tag   = req_word[29:INDEX_BITS];
  assign line_hit  = valid_q[idx] && (tag_mem[idx] == req_tag);
  assign accept    = (state == IDLE) && cache_req_valid;
  assign fill_done = (state == ALLOCATE) && mem_resp_valid;
  assign store_hit = (state == COMPARE) && line_hit && req_wen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_word <= '0;
      req_data <= '0;
      req_wen  <= 1'b0;
    end else if (accept) begin
      req_word <= cache_req_addr[31:2];
      req_data <= cache_req_data;
      req_wen  <= cache_req_wen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_done) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (store_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid_q gates their use.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[idx]  <= req_tag;
      data_mem[idx] <= mem_resp_data;
    end else if (store_hit) begin
      data_mem[idx] <= req_data;
    end
  end

  always_comb begin
    state_nx         = state;
    cache_stall      = 1'b0;
    cache_resp_valid = 1'b0;
    cache_resp_data  = '0;
    mem_req_valid    = 1'b0;
    mem_req_wen      = 1'b0;
    mem_req_addr     = '0;
    mem_req_data     = '0;
    case (state)
      IDLE: begin
        cache_stall = cache_req_valid;
        if (cache_req_valid) state_nx = COMPARE;
      end
      COMPARE: begin
        if (line_hit) begin
          cache_resp_valid = 1'b1;
          cache_resp_data  = req_wen ? req_data : data_mem[idx];
          state_nx         = IDLE;
        end else begin
          cache_stall = 1'b1;
          state_nx    = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        cache_stall   = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_wen   = 1'b1;
        mem_req_addr  = {tag_mem[idx], idx, 2'b00};
        mem_req_data  = data_mem[idx];
        if (mem_resp_valid) state_nx = ALLOCATE;
      end
      ALLOCATE: begin
        cache_stall   = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_word, 2'b00};
        if (mem_resp_valid) state_nx = COMPARE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed vector table, hand-written reset/spurious sequences,
// and random traffic checked against a flat architectural-memory model.
module tb_dcache_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cache_req_valid;
  logic        cache_req_wen;
  logic [31:0] cache_req_addr;
  logic [31:0] cache_req_data;
  logic        cache_resp_valid;
  logic [31:0] cache_resp_data;
  logic        cache_stall;
  logic        mem_req_valid;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  dcache_ctrl #(.INDEX_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cache_req_valid(cache_req_valid), .cache_req_wen(cache_req_wen),
    .cache_req_addr(cache_req_addr), .cache_req_data(cache_req_data),
    .cache_resp_valid(cache_resp_valid), .cache_resp_data(cache_resp_data),
    .cache_stall(cache_stall),
    .mem_req_valid(mem_req_valid), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // mem: what the bench's memory responder holds (written by DUT writebacks).
  // bm: what memory should hold. arch: what a load should observe.
  logic [31:0] mem  [logic [29:0]];
  logic [31:0] bm   [logic [29:0]];
  logic [31:0] arch [logic [29:0]];

  logic        mv [16];
  logic        md [16];
  logic [25:0] mt [16];

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;
  txn_t exq[$];

  function automatic logic [31:0] initv(input logic [29:0] w);
    return {w[13:0], 2'b01, w[15:0]} ^ 32'hA5C3_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [29:0] w);
    return mem.exists(w) ? mem[w] : initv(w);
  endfunction

  function automatic logic [31:0] bm_rd(input logic [29:0] w);
    return bm.exists(w) ? bm[w] : initv(w);
  endfunction

  function automatic logic [31:0] arch_rd(input logic [29:0] w);
    return arch.exists(w) ? arch[w] : initv(w);
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    mem[addr[31:2]]  = val;
    bm[addr[31:2]]   = val;
    arch[addr[31:2]] = val;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
      mt[i] = '0;
    end
    arch = bm;
  endtask

  task automatic run_req(input logic wen, input logic [31:0] addr, input logic [31:0] data,
                         input int lat, input bit spur,
                         output logic [31:0] rdata, output int cycles);
    logic [29:0] w;
    logic [29:0] ow;
    logic [3:0]  idx;
    logic [25:0] tg;
    bit          hit;
    bit          dirty_ev;
    bit          done;
    int          exp_cyc;
    int          cnt;
    logic [31:0] exp_data;
    txn_t        t;

    w        = addr[31:2];
    idx      = w[3:0];
    tg       = w[29:4];
    hit      = mv[idx] && (mt[idx] == tg);
    dirty_ev = !hit && mv[idx] && md[idx];
    exq.delete();
    if (dirty_ev) begin
      ow     = {mt[idx], idx};
      t.wen  = 1'b1;
      t.addr = {ow, 2'b00};
      t.data = arch_rd(ow);
      exq.push_back(t);
      bm[ow] = t.data;
    end
    if (!hit) begin
      t.wen  = 1'b0;
      t.addr = {w, 2'b00};
      t.data = '0;
      exq.push_back(t);
    end
    exp_cyc  = hit ? 1 : (dirty_ev ? 2 + 2 * lat : 2 + lat);
    exp_data = wen ? data : arch_rd(w);
    mv[idx]  = 1'b1;
    mt[idx]  = tg;
    md[idx]  = hit ? (md[idx] | wen) : wen;
    if (wen) arch[w] = data;

    @(negedge clk);
    cache_req_valid = 1'b1;
    cache_req_wen   = wen;
    cache_req_addr  = addr;
    cache_req_data  = data;
    #1 chk("stall_idle", 32'(cache_stall), 32'd1);

    cnt    = 0;
    cycles = 0;
    rdata  = '0;
    done   = 1'b0;
    for (int c = 1; c <= 4 * lat + 12 && !done; c++) begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'hBAD0_0000;
      chk("stall", 32'(cache_stall), 32'(c != exp_cyc));
      chk("mem_req_valid", 32'(mem_req_valid), 32'(c >= 2 && c < exp_cyc));
      if (cache_resp_valid) begin
        done   = 1'b1;
        cycles = c;
        rdata  = cache_resp_data;
        chk("resp_cycle", c, exp_cyc);
        chk("resp_data", rdata, exp_data);
        cache_req_valid = 1'b0;
      end else if (mem_req_valid && exq.size() > 0) begin
        chk("mem_req_wen", 32'(mem_req_wen), 32'(exq[0].wen));
        chk("mem_req_addr", mem_req_addr, exq[0].addr);
        if (exq[0].wen) chk("mem_req_data", mem_req_data, exq[0].data);
        cnt++;
        if (cnt == lat) begin
          if (mem_req_wen) mem[mem_req_addr[31:2]] = mem_req_data;
          else mem_resp_data = mem_rd(mem_req_addr[31:2]);
          mem_resp_valid = 1'b1;
          cnt = 0;
          void'(exq.pop_front());
        end
      end
      if (spur && c == 1) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0F0F_0F0F;
      end
    end
    if (!done) begin
      chk("resp_timeout", cycles, exp_cyc);
      cache_req_valid = 1'b0;
    end
    chk("mem_txn_left", exq.size(), 0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
  endtask

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
    bit          spur;
    logic [31:0] exp_data;
    int          exp_cyc;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] rd;
    int          cy;
    bit          found;

    tbl[0] = '{1'b0, 32'h0000_0040, 32'h0,         3, 1'b0, 32'hDEAD_BEEF, 5};
    tbl[1] = '{1'b0, 32'h0000_0040, 32'h0,         3, 1'b0, 32'hDEAD_BEEF, 1};
    tbl[2] = '{1'b1, 32'h0000_0040, 32'h1234_5678, 3, 1'b0, 32'h1234_5678, 1};
    tbl[3] = '{1'b0, 32'h0000_0440, 32'h0,         2, 1'b0, 32'h0BAD_F00D, 6};
    tbl[4] = '{1'b1, 32'h0000_0084, 32'hCAFE_F00D, 1, 1'b0, 32'hCAFE_F00D, 3};
    tbl[5] = '{1'b0, 32'h0000_0484, 32'h0,         2, 1'b0, 32'h3333_4444, 6};
    tbl[6] = '{1'b0, 32'h0000_0084, 32'h0,         1, 1'b0, 32'hCAFE_F00D, 3};
    tbl[7] = '{1'b0, 32'h0000_0040, 32'h0,         1, 1'b0, 32'h1234_5678, 3};
    tbl[8] = '{1'b0, 32'h0000_0040, 32'h0,         1, 1'b1, 32'h1234_5678, 1};
    tbl[9] = '{1'b0, 32'h0000_0440, 32'h0,         2, 1'b1, 32'h0BAD_F00D, 4};

    rst_n           = 1'b0;
    cache_req_valid = 1'b0;
    cache_req_wen   = 1'b0;
    cache_req_addr  = '0;
    cache_req_data  = '0;
    mem_resp_valid  = 1'b0;
    mem_resp_data   = '0;
    preload(32'h0000_0040, 32'hDEAD_BEEF);
    preload(32'h0000_0440, 32'h0BAD_F00D);
    preload(32'h0000_0084, 32'h1111_2222);
    preload(32'h0000_0484, 32'h3333_4444);
    model_reset();

    #12;
    chk("rst_resp_valid", 32'(cache_resp_valid), 32'd0);
    chk("rst_resp_data", cache_resp_data, 32'd0);
    chk("rst_stall", 32'(cache_stall), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_req_wen", 32'(mem_req_wen), 32'd0);
    chk("rst_mem_req_addr", mem_req_addr, 32'd0);
    chk("rst_mem_req_data", mem_req_data, 32'd0);
    cache_req_valid = 1'b1;
    #1 chk("rst_stall_follows", 32'(cache_stall), 32'd1);
    cache_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (i == 8) begin
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0F0F_0F0F;
        #1;
        chk("idle_spur_mem_req", 32'(mem_req_valid), 32'd0);
        chk("idle_spur_resp", 32'(cache_resp_valid), 32'd0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("idle_spur_after", 32'(cache_resp_valid | mem_req_valid), 32'd0);
      end
      run_req(tbl[i].wen, tbl[i].addr, tbl[i].data, tbl[i].lat, tbl[i].spur, rd, cy);
      chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp_data);
      chk($sformatf("tbl%0d_cycles", i), cy, tbl[i].exp_cyc);
    end

    // Reset in the middle of a fill discards a dirty line and drops the request at once.
    run_req(1'b1, 32'h0000_0040, 32'h7777_8888, 1, 1'b0, rd, cy);
    @(negedge clk);
    cache_req_valid = 1'b1;
    cache_req_wen   = 1'b0;
    cache_req_addr  = 32'h0000_0808;
    cache_req_data  = '0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (mem_req_valid) found = 1'b1;
    end
    chk("alloc_reached", 32'(mem_req_valid), 32'd1);
    chk("alloc_addr", mem_req_addr, 32'h0000_0808);
    chk("alloc_wen", 32'(mem_req_wen), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_mem_req_valid", 32'(mem_req_valid), 32'd0);
    cache_req_valid = 1'b0;
    #1 chk("rst_mid_stall", 32'(cache_stall), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_req(1'b0, 32'h0000_0040, 32'h0, 2, 1'b0, rd, cy);
    chk("post_rst_cycles", cy, 4);
    chk("post_rst_data", rd, 32'h1234_5678);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2)
          | 32'($urandom_range(0, 3));
      run_req(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(1, 4)),
              ($urandom_range(0, 7) == 0), rd, cy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache with a one-word line, placed between the MEM-stage cache request decode and main memory. It accepts the per-instruction `cache_req_valid`/`cache_req_wen` pair from the MEM stage, together with the address and store data. It serves hits from an internal tag/data array and resolves misses through a single-outstanding memory handshake. While a request is unresolved it stalls the pipeline.

## Interface
- INDEX_BITS, 4, number of index bits; the cache holds 2^INDEX_BITS lines of one 32-bit word each.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cache_req_valid  in  1  MEM stage holds a load or store request.
- cache_req_wen  in  1  1 = store, 0 = load.
- cache_req_addr  in  32  byte address; bits [1:0] are ignored.
- cache_req_data  in  32  store data.
- cache_resp_valid  out  1  request completes this cycle.
- cache_resp_data  out  32  load data. For stores it carries the store data.
- cache_stall  out  1  pipeline must hold MEM-stage inputs stable.
- mem_req_valid  out  1  memory request is active.
- mem_req_wen  out  1  1 = writeback, 0 = line fill.
- mem_req_addr  out  32  word-aligned memory address.
- mem_req_data  out  32  writeback data.
- mem_resp_valid  in  1  memory completes the current request (a one-cycle pulse).
- mem_resp_data  in  32  fill data, valid when mem_resp_valid is high.

## Operation
- Address split:
  - index = addr[INDEX_BITS+1:2]
  - tag = addr[31:INDEX_BITS+2]
- Per line state: valid, dirty, tag, data. Only valid and dirty are reset; tag and data are left unreset.
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE:
  - If cache_req_valid is high, latch addr, data and wen, then go to COMPARE.
  - cache_stall equals cache_req_valid.
- COMPARE: hit = valid[index] and tag match.
  - On a hit:
    - cache_resp_valid = 1 and cache_stall = 0 (both combinational).
    - For a load, cache_resp_data = the line data.
    - For a store, the line data becomes the store data and dirty = 1 at the clock edge.
    - Next state is IDLE.
  - On a miss with valid and dirty set, go to WRITEBACK.
  - On any other miss, go to ALLOCATE.
  - cache_stall = 1 on a miss.
- WRITEBACK:
  - mem_req_valid = 1, mem_req_wen = 1.
  - mem_req_addr = {old tag, index, 2'b00}; mem_req_data = old line data.
  - Hold until mem_resp_valid, then go to ALLOCATE.
- ALLOCATE:
  - mem_req_valid = 1, mem_req_wen = 0, mem_req_addr = {latched addr[31:2], 2'b00}.
  - On mem_resp_valid, write the line with data = mem_resp_data, the new tag, valid = 1, dirty = 0, then go to COMPARE.
  - The re-entry to COMPARE always hits, so a store miss merges its data there.
- mem_* outputs are decoded from the state and latched registers and stay stable for the whole state. They are 0 in IDLE and COMPARE.
- mem_resp_valid is ignored in IDLE and COMPARE.
- Only one memory request is outstanding at a time; there are no back-to-back merges.

## Timing
- Reset values: state IDLE, all valid and dirty bits 0, latched request 0.
  - All outputs are 0, except cache_stall, which follows cache_req_valid.
- Reset asserted mid-operation: the block returns to IDLE immediately, and mem_req_valid drops in the same cycle (asynchronously). Dirty data is discarded.
- Hit: the request is seen in IDLE at cycle 0. COMPARE in cycle 1 asserts cache_resp_valid, with stall low. The pipeline advances at the end of cycle 1.
- Clean miss: cycle 1 is COMPARE (miss) and ALLOCATE starts in cycle 2.
  - If mem_resp_valid arrives in cycle N, COMPARE-with-hit is cycle N+1.
- Dirty miss: WRITEBACK runs from cycle 2 until its mem_resp_valid, then ALLOCATE runs as above.
- A new request may be presented in the cycle after the completing COMPARE. There are no idle bubbles beyond the IDLE acceptance cycle.
- Upstream must keep cache_req_* stable while cache_stall = 1. Only the value latched in IDLE is used.

## Test plan
- Read miss: after reset, load 0x0000_0040. Required: COMPARE misses, then ALLOCATE drives mem_req_valid=1, wen=0, addr=0x40. Memory answers with 0xDEADBEEF after 3 cycles. Required: next cycle cache_resp_valid=1 with data 0xDEADBEEF, and stall drops in that same cycle.
- Read hit: repeat the load of 0x40. Required: resp_valid in the second cycle with data 0xDEADBEEF, and mem_req_valid never asserts.
- Dirty eviction: store 0x12345678 to 0x40 (a hit), then load 0x440 (same index, tag 0x11). Required: WRITEBACK with addr 0x40, data 0x12345678, wen=1. After its response, ALLOCATE with addr 0x440. The load returns the fill data.
- Store miss: store 0xCAFEF00D to 0x84 with a clean line. Required: fill from 0x84, then a COMPARE hit with the line holding 0xCAFEF00D and dirty=1. A later conflicting load writes back 0xCAFEF00D.
- Reset mid-ALLOCATE: assert rst_n=0 while mem_req_valid=1. Required: mem_req_valid=0 in the same cycle. After release, a load of 0x40 misses again.
- Spurious response: pulse mem_resp_valid in IDLE and in COMPARE. Required: no state or array change.
